// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared types and constants for the secure debug read port
package dbg_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_SCRUB  = 2'd1,
        ST_DEBUG  = 2'd2
    } dbg_state_e;

    // Value returned on the debug path for every refused read
    localparam logic [WORD_W-1:0] ERR_RDATA = '0;
    localparam logic              ERR_FLAG  = 1'b1;

endpackage

// File: rtl/dbg_key_store.sv
// rtl/dbg_key_store.sv - key register with word-serial scrub and validity tracking
module dbg_key_store
    import dbg_pkg::*;
#(
    parameter int KEY_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_en,
    input  logic [WORD_W*KEY_WORDS-1:0] key_in,
    input  logic                        scrub_start,
    input  logic                        scrub_en,
    output logic [WORD_W*KEY_WORDS-1:0] key_q,
    output logic                        key_valid_q,
    output logic                        scrub_last
);

    localparam int CNT_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [WORD_W*KEY_WORDS-1:0]   key_d;
    logic                          key_valid_d;
    logic [KEY_WORDS-1:0]          word_clr;

    // One-hot clear strobe: the word selected by the scrub counter is zeroed this cycle
    always_comb begin
        word_clr = '0;
        for (int i = 0; i < KEY_WORDS; i++) begin
            word_clr[i] = scrub_en && (cnt_q == CNT_W'(i));
        end
        scrub_last = scrub_en && (cnt_q == CNT_W'(KEY_WORDS - 1));
    end

    // Next key contents, validity and scrub counter
    always_comb begin
        key_d = key_q;
        if (load_en) begin
            key_d = key_in;
        end
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (word_clr[i]) begin
                key_d[i*WORD_W +: WORD_W] = '0;
            end
        end

        key_valid_d = key_valid_q;
        if (scrub_start) begin
            key_valid_d = 1'b0;
        end else if (load_en) begin
            key_valid_d = 1'b1;
        end

        cnt_d = '0;
        if (scrub_en && !scrub_last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Key store registers
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            key_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/secure_debug_read_port.sv
// rtl/secure_debug_read_port.sv - debug read responder guarding a scrubbed key register
module secure_debug_read_port
    import dbg_pkg::*;
#(
    parameter int NUM_WORDS = 8,
    parameter int KEY_WORDS = 4,
    parameter int ADDR_W    = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    debug_mode,
    input  logic                                    key_load,
    input  logic [WORD_W*KEY_WORDS-1:0]             key_in,
    input  logic [WORD_W*(NUM_WORDS-KEY_WORDS)-1:0] status_in,
    output logic [WORD_W*KEY_WORDS-1:0]             key_out,
    output logic                                    key_valid,
    output logic                                    scrub_busy,
    input  logic                                    dbg_req,
    input  logic [ADDR_W-1:0]                       dbg_addr,
    output logic                                    dbg_ack,
    output logic [WORD_W-1:0]                       dbg_rdata,
    output logic                                    dbg_err
);

    localparam int STATUS_WORDS = NUM_WORDS - KEY_WORDS;

    dbg_state_e                  state_q, state_d;
    logic                        ack_q, ack_d;
    logic [WORD_W-1:0]           rdata_q, rdata_d;
    logic                        err_q, err_d;

    logic                        in_normal, in_scrub, in_debug;
    logic                        load_en, scrub_start, scrub_last;
    logic                        accept;
    logic [WORD_W*KEY_WORDS-1:0] key_q;
    logic                        key_valid_q;
    logic [ADDR_W-1:0]           st_idx;
    logic [WORD_W-1:0]           status_word;
    logic                        addr_in_key, addr_out_of_range;

    dbg_key_store #(
        .KEY_WORDS (KEY_WORDS)
    ) u_key_store (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .key_in      (key_in),
        .scrub_start (scrub_start),
        .scrub_en    (in_scrub),
        .key_q       (key_q),
        .key_valid_q (key_valid_q),
        .scrub_last  (scrub_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: debug entry always scrubs first; debug exit waits out a response in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: if (debug_mode) state_d = ST_SCRUB;
            ST_SCRUB:  if (scrub_last) state_d = debug_mode ? ST_DEBUG : ST_NORMAL;
            ST_DEBUG:  if (!debug_mode && !ack_q) state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase
    end

    // State-decoded controls and key-side outputs; the key never leaves outside NORMAL
    always_comb begin
        in_normal   = (state_q == ST_NORMAL);
        in_scrub    = (state_q == ST_SCRUB);
        in_debug    = (state_q == ST_DEBUG);
        scrub_start = in_normal && debug_mode;
        load_en     = in_normal && !debug_mode && key_load;
        accept      = dbg_req && !ack_q && (in_debug || (in_normal && !debug_mode));
        scrub_busy  = in_scrub;
        key_valid   = in_normal && key_valid_q;
        key_out     = in_normal ? key_q : '0;
    end

    // Status word select and address classification, compared unsigned at full width
    always_comb begin
        st_idx            = dbg_addr - ADDR_W'(KEY_WORDS);
        addr_in_key       = ({1'b0, dbg_addr} < (ADDR_W+1)'(KEY_WORDS));
        addr_out_of_range = ({1'b0, dbg_addr} >= (ADDR_W+1)'(NUM_WORDS));
        status_word       = '0;
        for (int k = 0; k < STATUS_WORDS; k++) begin
            if (st_idx == ADDR_W'(k)) begin
                status_word = status_in[k*WORD_W +: WORD_W];
            end
        end
    end

    // Response computed at acceptance, registered for exactly one cycle
    always_comb begin
        ack_d   = accept;
        rdata_d = '0;
        err_d   = 1'b0;
        if (accept) begin
            if (in_debug && !addr_in_key && !addr_out_of_range) begin
                rdata_d = status_word;
                err_d   = 1'b0;
            end else begin
                rdata_d = ERR_RDATA;
                err_d   = ERR_FLAG;
            end
        end
    end

    // Response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response outputs
    always_comb begin
        dbg_ack   = ack_q;
        dbg_rdata = rdata_q;
        dbg_err   = err_q;
    end

endmodule

// File: tb/tb_secure_debug_read_port.sv
// tb/tb_secure_debug_read_port.sv - directed self-checking bench for secure_debug_read_port
module tb_secure_debug_read_port;

    localparam int NUM_WORDS = 8;
    localparam int KEY_WORDS = 4;
    localparam int ADDR_W    = 4;

    logic                                clk = 1'b0;
    logic                                rst;
    logic                                debug_mode;
    logic                                key_load;
    logic [32*KEY_WORDS-1:0]             key_in;
    logic [32*(NUM_WORDS-KEY_WORDS)-1:0] status_in;
    logic [32*KEY_WORDS-1:0]             key_out;
    logic                                key_valid;
    logic                                scrub_busy;
    logic                                dbg_req;
    logic [ADDR_W-1:0]                   dbg_addr;
    logic                                dbg_ack;
    logic [31:0]                         dbg_rdata;
    logic                                dbg_err;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [127:0] KEY_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] KEY_B = 128'hFFFF0000FFFF0000FFFF0000FFFF0000;

    secure_debug_read_port #(
        .NUM_WORDS (NUM_WORDS),
        .KEY_WORDS (KEY_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .debug_mode (debug_mode),
        .key_load   (key_load),
        .key_in     (key_in),
        .status_in  (status_in),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .scrub_busy (scrub_busy),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .dbg_err    (dbg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              err;
        logic [31:0]       rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] key_word(input int i);
        logic [127:0] k;
        k = dut.u_key_store.key_q;
        return k[i*32 +: 32];
    endfunction

    // One isolated read: accept on the next edge, ack for exactly one cycle
    task automatic do_read(input string nm, input logic [ADDR_W-1:0] a,
                           input logic e_err, input logic [31:0] e_rdata);
        dbg_req  = 1'b1;
        dbg_addr = a;
        step();
        chk({nm, "_ack"}, {127'b0, dbg_ack}, 128'd1);
        chk({nm, "_err"}, {127'b0, dbg_err}, {127'b0, e_err});
        chk({nm, "_rdata"}, {96'b0, dbg_rdata}, {96'b0, e_rdata});
        dbg_req = 1'b0;
        step();
        chk({nm, "_ack_drop"}, {127'b0, dbg_ack}, 128'd0);
        chk({nm, "_rdata_idle"}, {96'b0, dbg_rdata}, 128'd0);
    endtask

    initial begin
        vecs[0] = '{4'd0,  1'b1, 32'h0};
        vecs[1] = '{4'd2,  1'b1, 32'h0};
        vecs[2] = '{4'd3,  1'b1, 32'h0};
        vecs[3] = '{4'd4,  1'b0, 32'hDEADBEEF};
        vecs[4] = '{4'd5,  1'b0, 32'hCAFEF00D};
        vecs[5] = '{4'd6,  1'b0, 32'h12345678};
        vecs[6] = '{4'd7,  1'b0, 32'hA5A55A5A};
        vecs[7] = '{4'd9,  1'b1, 32'h0};
        vecs[8] = '{4'd15, 1'b1, 32'h0};

        rst        = 1'b1;
        debug_mode = 1'b0;
        key_load   = 1'b0;
        key_in     = '0;
        status_in  = {32'hA5A55A5A, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};
        dbg_req    = 1'b0;
        dbg_addr   = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_key_valid", {127'b0, key_valid}, 128'd0);
        chk("rst_scrub_busy", {127'b0, scrub_busy}, 128'd0);
        chk("rst_ack", {127'b0, dbg_ack}, 128'd0);
        chk("rst_err", {127'b0, dbg_err}, 128'd0);
        chk("rst_key_out", key_out, 128'd0);

        // Key load in NORMAL
        key_load = 1'b1;
        key_in   = KEY_A;
        step();
        key_load = 1'b0;
        chk("load_key_valid", {127'b0, key_valid}, 128'd1);
        chk("load_key_out", key_out, KEY_A);

        // Reads refused in NORMAL, including a status address
        do_read("normal_a0", 4'd0, 1'b1, 32'h0);
        do_read("normal_a4", 4'd4, 1'b1, 32'h0);

        // Debug entry with req held and a simultaneous key_load that must be ignored
        debug_mode = 1'b1;
        key_load   = 1'b1;
        key_in     = KEY_B;
        dbg_req    = 1'b1;
        dbg_addr   = 4'd4;
        step();                                  // edge t
        key_load = 1'b0;
        chk("entry_scrub_busy", {127'b0, scrub_busy}, 128'd1);
        chk("entry_key_valid", {127'b0, key_valid}, 128'd0);
        chk("entry_key_out", key_out, 128'd0);
        chk("entry_ack", {127'b0, dbg_ack}, 128'd0);
        chk("entry_no_load", {96'b0, key_word(3)}, {96'b0, KEY_A[127:96]});
        for (int i = 0; i < KEY_WORDS; i++) begin
            step();                              // edge t+1+i
            chk($sformatf("scrub_w%0d_zero", i), {96'b0, key_word(i)}, 128'd0);
            if (i < KEY_WORDS - 1) begin
                chk($sformatf("scrub_w%0d_kept", i + 1), {96'b0, key_word(i + 1)},
                    {96'b0, KEY_A[(i+1)*32 +: 32]});
                chk($sformatf("scrub_busy_%0d", i), {127'b0, scrub_busy}, 128'd1);
            end else begin
                chk("scrub_done_busy", {127'b0, scrub_busy}, 128'd0);
            end
            chk($sformatf("scrub_stall_%0d", i), {127'b0, dbg_ack}, 128'd0);
        end
        step();                                  // edge t+5: held req accepted in DEBUG
        chk("held_ack", {127'b0, dbg_ack}, 128'd1);
        chk("held_rdata", {96'b0, dbg_rdata}, {96'b0, 32'hDEADBEEF});
        chk("held_err", {127'b0, dbg_err}, 128'd0);
        step();
        chk("held_gap", {127'b0, dbg_ack}, 128'd0);
        step();
        chk("held_second_ack", {127'b0, dbg_ack}, 128'd1);
        dbg_req = 1'b0;
        step();
        chk("held_release", {127'b0, dbg_ack}, 128'd0);

        // Table of DEBUG reads across key, status and out-of-range addresses
        for (int v = 0; v < 9; v++) begin
            do_read($sformatf("tbl_a%0d", vecs[v].addr), vecs[v].addr, vecs[v].err, vecs[v].rdata);
        end

        // Leave debug: key remains scrubbed until a fresh load
        debug_mode = 1'b0;
        step();
        chk("exit_key_valid", {127'b0, key_valid}, 128'd0);
        chk("exit_key_out", key_out, 128'd0);
        chk("exit_scrub_busy", {127'b0, scrub_busy}, 128'd0);
        do_read("exit_normal_a4", 4'd4, 1'b1, 32'h0);
        chk("exit_key_valid_later", {127'b0, key_valid}, 128'd0);
        key_load = 1'b1;
        key_in   = '0;
        step();
        key_load = 1'b0;
        chk("zero_load_valid", {127'b0, key_valid}, 128'd1);
        chk("zero_load_out", key_out, 128'd0);

        // Reset in the middle of a scrub
        key_load = 1'b1;
        key_in   = KEY_A;
        step();
        key_load   = 1'b0;
        debug_mode = 1'b1;
        step();                                  // edge t
        step();
        step();                                  // two words scrubbed
        chk("midrst_pre_busy", {127'b0, scrub_busy}, 128'd1);
        rst        = 1'b1;
        debug_mode = 1'b0;
        step();
        rst = 1'b0;
        chk("midrst_busy", {127'b0, scrub_busy}, 128'd0);
        chk("midrst_key_valid", {127'b0, key_valid}, 128'd0);
        chk("midrst_key_out", key_out, 128'd0);
        chk("midrst_key_store", dut.u_key_store.key_q, 128'd0);
        chk("midrst_ack", {127'b0, dbg_ack}, 128'd0);
        do_read("midrst_normal_a5", 4'd5, 1'b1, 32'h0);

        // debug_mode dropped mid-scrub: scrub completes, then NORMAL
        key_load = 1'b1;
        key_in   = KEY_B;
        step();
        key_load = 1'b0;
        chk("drop_loaded", key_out, KEY_B);
        debug_mode = 1'b1;
        step();                                  // edge t
        debug_mode = 1'b0;
        for (int i = 0; i < KEY_WORDS - 1; i++) begin
            step();
            chk($sformatf("drop_busy_%0d", i), {127'b0, scrub_busy}, 128'd1);
        end
        step();
        chk("drop_done_busy", {127'b0, scrub_busy}, 128'd0);
        chk("drop_key_store", dut.u_key_store.key_q, 128'd0);
        chk("drop_key_valid", {127'b0, key_valid}, 128'd0);
        do_read("drop_normal_a4", 4'd4, 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
